rvc_asap_5pl_lsu: RTL
=====================

# rvc_asap_5pl_lsu

Load/store unit sitting directly upstream of the memory wrapper in the 5-stage core.
- Takes the Q103H load/store request from the execute/memory pipeline and drives the wrapper's D_MEM request (address, write data, byte enables, read/write enables).
- Consumes the wrapper's Q104H read response and returns aligned, sign/zero-extended load data to writeback.
- Splits misaligned accesses into two word-aligned beats, stalling the pipeline for one cycle.

## Interface
Parameters:
- none

Ports:
- Clock  in  1  core clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- RdEnQ103H  in  1  load request this cycle
- WrEnQ103H  in  1  store request this cycle
- AddressQ103H  in  32  byte address
- WrDataQ103H  in  32  store data, right-justified
- Funct3Q103H  in  3  RV32 funct3:
  - 000 = B, 001 = H, 010 = W
  - 100 = BU, 101 = HU (loads only)
  - other codes are treated as W
- LsuStallQ103H  out  1  hold Q100H–Q103H; the request is re-presented next cycle
- MisalignQ103H  out  1  misaligned access rejected (only without split support)
- DMemAddressQ103H  out  32  word-aligned address to memory wrapper
- DMemWrDataQ103H  out  32  lane-aligned store data
- DMemByteEnQ103H  out  4  byte lanes
- DMemWrEnQ103H  out  1  write strobe
- DMemRdEnQ103H  out  1  read strobe
- DMemRdRspQ104H  in  32  wrapper read data, one cycle after DMemRdEnQ103H
- LoadDataQ104H  out  32  final load result
- LoadValidQ104H  out  1  LoadDataQ104H valid this cycle

## Operation
Request decode:
- Size mask m: 0001 for B, 0011 for H, 1111 for W.
- off = AddressQ103H[1:0].
- mask8 = m << off (8 bits).
- Access is misaligned when mask8[7:4] != 0.
- If WrEnQ103H and RdEnQ103H are both high, the write wins and the read is ignored.

Aligned access (state IDLE):
- DMemAddressQ103H = {AddressQ103H[31:2], 00}.
- DMemByteEnQ103H = mask8[3:0].
- DMemWrDataQ103H = WrDataQ103H << 8·off.
- Enables pass through.

Split access, beat 0 (state IDLE, misaligned):
- Same address, ByteEn = mask8[3:0], data shifted as for an aligned access.
- LsuStallQ103H = 1.
- FSM moves to SPLIT.
- The internal hold register captures base+4, mask8[7:4], WrDataQ103H >> 8·(4−off), off, funct3, and rd/wr.

Split access, beat 1 (state SPLIT):
- Outputs are driven from the hold register; the pipeline inputs are ignored.
- DMemAddressQ103H = base + 4, mod 2^32.
- LsuStallQ103H = 0.
- FSM moves back to IDLE.

FSM:
- Two states only: IDLE → SPLIT on a misaligned request; SPLIT → IDLE unconditionally.

Q104H pipeline (registered from Q103H):
- Fields: off, funct3, isLoad, beatTag ∈ {single, first, second}.
- On tag first: DMemRdRspQ104H is captured into Lo; LoadValidQ104H = 0.
- On tag single: raw = {32'b0, DMemRdRspQ104H} >> 8·off.
- On tag second: raw = {DMemRdRspQ104H, Lo} >> 8·off.
- Result extension: B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed as is.
- LoadValidQ104H = 1 on single/second beats of loads only.

## Timing
- Reset values:
  - FSM = IDLE; hold register, Lo and Q104H tags = 0.
  - LoadValidQ104H = 0, LoadDataQ104H = 0.
  - While Rst is high: DMemWrEnQ103H, DMemRdEnQ103H, LsuStallQ103H and MisalignQ103H are forced to 0.
- Latency for an aligned load presented in cycle N: LoadValidQ104H in N+1.
- Latency for a split load presented in cycle N:
  - Beat 0 in N, beat 1 in N+1.
  - LoadValidQ104H only in N+2.
  - The stall is high in N only.
- A split store writes bytes in N and N+1; there is no Q104H output.
- The Q103H request outputs are combinational from the inputs/hold register; the Q104H outputs are combinational from registered tags plus DMemRdRspQ104H.
- Reset during SPLIT: return to IDLE and do not issue beat 1. LoadValidQ104H must be 0 in the following cycle.
- Address 0xFFFF_FFFD, W: beat 1 address wraps to 0x0000_0000.
- A new request arriving in the cycle while SPLIT is active is ignored. The upstream stage holds it via the prior stall and re-presents it in the following cycle.

## Configuration
- MISALIGNED_SPLIT_EN defined:
  - Two-beat splitting as above.
  - MisalignQ103H is tied to 0.
- MISALIGNED_SPLIT_EN undefined:
  - No SPLIT state and no hold/Lo registers.
  - A misaligned request asserts MisalignQ103H for that cycle.
  - DMemWrEnQ103H/DMemRdEnQ103H = 0, LsuStallQ103H = 0, and there is no LoadValidQ104H.

## Test plan
- Aligned LW at 0x1000, memory word 0x8899AABB → DMemByteEn 1111, LoadValidQ104H next cycle with 0x8899AABB.
- LB at 0x1003, word 0x80000000 → ByteEn 1000, LoadData 0xFFFFFF80; same with LBU → 0x00000080.
- SH at 0x1002 data 0x0000BEEF → ByteEn 1100, DMemWrData 0xBEEF0000, no stall.
- With split enabled, SW at 0x1001 data 0xDDCCBBAA → cycle N: addr 0x1000, ByteEn 1110, data 0xCCBBAA00, stall=1; cycle N+1: addr 0x1004, ByteEn 0001, data 0x000000DD, stall=0.
- With split enabled, LH at 0x1003 (words 0x11xxxxxx at 0x1000, 0xxxxxxx22 at 0x1004) → LoadValid only at N+2, LoadData 0x00002211. Assert Rst in N+1 of a repeat → no LoadValid, FSM IDLE.
- With split disabled, LW at 0x2002 → MisalignQ103H=1, no enables, no LoadValid. Simultaneous RdEn+WrEn at 0x3000 → write only.

Source files
------------

// File: rtl/rvc_asap_5pl_lsu.sv
// Load/store unit: drives the D_MEM wrapper request in Q103H and aligns/extends load data in Q104H.
// Macro MISALIGNED_SPLIT_EN enables two-beat misaligned splitting; when undefined, misaligned requests are rejected.
module rvc_asap_5pl_lsu (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        RdEnQ103H,
    input  logic        WrEnQ103H,
    input  logic [31:0] AddressQ103H,
    input  logic [31:0] WrDataQ103H,
    input  logic [2:0]  Funct3Q103H,
    output logic        LsuStallQ103H,
    output logic        MisalignQ103H,
    output logic [31:0] DMemAddressQ103H,
    output logic [31:0] DMemWrDataQ103H,
    output logic [3:0]  DMemByteEnQ103H,
    output logic        DMemWrEnQ103H,
    output logic        DMemRdEnQ103H,
    input  logic [31:0] DMemRdRspQ104H,
    output logic [31:0] LoadDataQ104H,
    output logic        LoadValidQ104H
);

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_SINGLE,
        TAG_FIRST,
        TAG_SECOND
    } beat_tag_e;

    logic [3:0]  size_mask;
    logic [1:0]  req_off;
    logic [7:0]  mask8;
    logic        misaligned;
    logic        req_wr;
    logic        req_rd;
    logic [31:0] word_addr;
    logic [31:0] lane_data;

    beat_tag_e   tag_d;
    beat_tag_e   q104_tag;
    logic [1:0]  off_d;
    logic [1:0]  q104_off;
    logic [2:0]  funct3_d;
    logic [2:0]  q104_funct3;
    logic        q104_is_load;
    logic [31:0] rsp_hi_word;
    logic [31:0] rsp_lo_word;
    logic [63:0] raw64;
    logic [31:0] raw;
    logic [31:0] ext;
    logic        unused_raw_hi;

    always_comb begin
        case (Funct3Q103H)
            3'b000, 3'b100: size_mask = 4'b0001;
            3'b001, 3'b101: size_mask = 4'b0011;
            default:        size_mask = 4'b1111;
        endcase
    end

    assign req_off    = AddressQ103H[1:0];
    assign mask8      = {4'b0000, size_mask} << req_off;
    assign misaligned = |mask8[7:4];
    // a simultaneous read and write is treated as a write only
    assign req_wr     = WrEnQ103H;
    assign req_rd     = RdEnQ103H & ~WrEnQ103H;
    assign word_addr  = {AddressQ103H[31:2], 2'b00};
    assign lane_data  = WrDataQ103H << {req_off, 3'b000};

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic {
        ST_IDLE,
        ST_SPLIT
    } lsu_state_e;

    lsu_state_e  state;
    lsu_state_e  next_state;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [31:0] lo_word;
    logic [3:0]  hold_be;
    logic [1:0]  hold_off;
    logic [2:0]  hold_funct3;
    logic        hold_rd;
    logic        hold_wr;
    logic [5:0]  hi_shift;

    assign hi_shift = 6'd32 - {1'b0, req_off, 3'b000};

    always_comb begin
        next_state       = state;
        LsuStallQ103H    = 1'b0;
        MisalignQ103H    = 1'b0;
        DMemAddressQ103H = word_addr;
        DMemByteEnQ103H  = mask8[3:0];
        DMemWrDataQ103H  = lane_data;
        DMemWrEnQ103H    = req_wr;
        DMemRdEnQ103H    = req_rd;
        tag_d            = req_rd ? TAG_SINGLE : TAG_NONE;
        off_d            = req_off;
        funct3_d         = Funct3Q103H;
        case (state)
            ST_IDLE: begin
                if ((req_wr || req_rd) && misaligned) begin
                    LsuStallQ103H = 1'b1;
                    next_state    = ST_SPLIT;
                    tag_d         = req_rd ? TAG_FIRST : TAG_NONE;
                end
            end
            ST_SPLIT: begin
                next_state       = ST_IDLE;
                DMemAddressQ103H = hold_addr;
                DMemByteEnQ103H  = hold_be;
                DMemWrDataQ103H  = hold_wdata;
                DMemWrEnQ103H    = hold_wr;
                DMemRdEnQ103H    = hold_rd;
                tag_d            = hold_rd ? TAG_SECOND : TAG_NONE;
                off_d            = hold_off;
                funct3_d         = hold_funct3;
            end
            default: next_state = ST_IDLE;
        endcase
        if (Rst) begin
            DMemWrEnQ103H = 1'b0;
            DMemRdEnQ103H = 1'b0;
            LsuStallQ103H = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state       <= ST_IDLE;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            hold_be     <= '0;
            hold_off    <= '0;
            hold_funct3 <= '0;
            hold_rd     <= 1'b0;
            hold_wr     <= 1'b0;
            lo_word     <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_SPLIT) begin
                hold_addr   <= word_addr + 32'd4;
                hold_be     <= mask8[7:4];
                hold_wdata  <= WrDataQ103H >> hi_shift;
                hold_off    <= req_off;
                hold_funct3 <= Funct3Q103H;
                hold_rd     <= req_rd;
                hold_wr     <= req_wr;
            end
            if (q104_tag == TAG_FIRST) begin
                lo_word <= DMemRdRspQ104H;
            end
        end
    end

    assign rsp_hi_word = (q104_tag == TAG_SECOND) ? DMemRdRspQ104H : 32'h0;
    assign rsp_lo_word = (q104_tag == TAG_SECOND) ? lo_word : DMemRdRspQ104H;
`else
    logic reject;

    assign reject = (req_wr || req_rd) && misaligned;

    always_comb begin
        LsuStallQ103H    = 1'b0;
        MisalignQ103H    = reject & ~Rst;
        DMemAddressQ103H = word_addr;
        DMemByteEnQ103H  = mask8[3:0];
        DMemWrDataQ103H  = lane_data;
        DMemWrEnQ103H    = req_wr & ~reject & ~Rst;
        DMemRdEnQ103H    = req_rd & ~reject & ~Rst;
        tag_d            = (req_rd && !reject) ? TAG_SINGLE : TAG_NONE;
        off_d            = req_off;
        funct3_d         = Funct3Q103H;
    end

    assign rsp_hi_word = 32'h0;
    assign rsp_lo_word = DMemRdRspQ104H;
`endif

    always_ff @(posedge Clock) begin
        if (Rst) begin
            q104_tag     <= TAG_NONE;
            q104_off     <= '0;
            q104_funct3  <= '0;
            q104_is_load <= 1'b0;
        end else begin
            q104_tag     <= tag_d;
            q104_off     <= off_d;
            q104_funct3  <= funct3_d;
            q104_is_load <= (tag_d != TAG_NONE);
        end
    end

    // the second beat's word sits above the captured first word, so one shift aligns both cases
    assign raw64         = {rsp_hi_word, rsp_lo_word} >> {q104_off, 3'b000};
    assign raw           = raw64[31:0];
    assign unused_raw_hi = ^raw64[63:32];

    assign LoadValidQ104H = q104_is_load && (q104_tag == TAG_SINGLE || q104_tag == TAG_SECOND);

    always_comb begin
        case (q104_funct3)
            3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'h0, raw[7:0]};
            3'b101:  ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
        LoadDataQ104H = LoadValidQ104H ? ext : 32'h0;
    end

endmodule
